spi_slave_if: RTL and testbench

- SPI responder (slave) for the configuration port. It is the far end of the link driven by the team's SPI master and its clock generator.
- Oversamples the external sclk, ss_n and mosi on the system clock, deserialises mosi into words and serialises a host-supplied word onto miso.
- Supports all four CPOL/CPHA modes. Host side uses a valid/ready transmit interface and a pulsed receive interface.

---
 rtl/spi_slave_if.sv | 144 ++++++++++++++
 tb/tb_spi_slave_if.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_if.sv
// SPI responder for the configuration port.
// Oversamples sclk/ss_n/mosi on clk_in, deserialises mosi into WIDTH-bit words
// and serialises a one-entry buffered host word onto miso. All CPOL/CPHA modes.
module spi_slave_if #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             cpol,
  input  logic             cpha,
  input  logic             sclk,
  input  logic             ss_n,
  input  logic             mosi,
  output logic             miso,
  output logic             miso_oe,
  input  logic [WIDTH-1:0] tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_valid,
  output logic             tx_underrun
);
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [2:0]       sclk_q;
  logic [1:0]       ss_q;
  logic [1:0]       mosi_q;
  logic             ss_prev;
  logic             active;
  logic [CW-1:0]    bit_cnt;
  logic             load_pending;
  logic [WIDTH-1:0] tx_sr;
  logic [WIDTH-1:0] rx_sr;
  logic [WIDTH-1:0] tx_buf;
  logic             buf_full;

  logic             sclk_chg, lead, trail, sample_edge, drive_edge;
  logic             frame_start, frame_end, do_load, accept;
  logic [WIDTH-1:0] rx_next, tx_shift;

  // Edge classification relative to the idle level; only meaningful while selected.
  assign sclk_chg    = sclk_q[1] ^ sclk_q[2];
  assign lead        = active & sclk_chg & (sclk_q[1] != cpol);
  assign trail       = active & sclk_chg & (sclk_q[1] == cpol);
  assign sample_edge = cpha ? trail : lead;
  assign drive_edge  = cpha ? lead : trail;

  // ss_prev must have seen ss_n high, so a select held low through reset
  // does not restart a frame until ss_n toggles.
  assign frame_start = ss_prev & ~ss_q[1];
  assign frame_end   = active & ss_q[1];

  assign do_load  = (frame_start & ~cpha) | (drive_edge & load_pending);
  assign accept   = tx_valid & ~buf_full;
  assign tx_ready = ~buf_full;

  assign rx_next  = MSB_FIRST ? {rx_sr[WIDTH-2:0], mosi_q[1]} : {mosi_q[1], rx_sr[WIDTH-1:1]};
  assign tx_shift = MSB_FIRST ? {tx_sr[WIDTH-2:0], 1'b0}      : {1'b0, tx_sr[WIDTH-1:1]};
  assign miso     = miso_oe & (MSB_FIRST ? tx_sr[WIDTH-1] : tx_sr[0]);

  // Pin synchronisers; sclk carries one extra stage for edge detection.
  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      sclk_q  <= '0;
      ss_q    <= '0;
      mosi_q  <= '0;
      ss_prev <= 1'b0;
    end else begin
      sclk_q  <= {sclk_q[1:0], sclk};
      ss_q    <= {ss_q[0], ss_n};
      mosi_q  <= {mosi_q[0], mosi};
      ss_prev <= ss_q[1];
    end
  end

  // Frame control, tx/rx shift registers and receive strobes.
  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      active       <= 1'b0;
      miso_oe      <= 1'b0;
      bit_cnt      <= '0;
      load_pending <= 1'b0;
      tx_sr        <= '0;
      rx_sr        <= '0;
      rx_data      <= '0;
      rx_valid     <= 1'b0;
      tx_underrun  <= 1'b0;
    end else begin
      rx_valid    <= 1'b0;
      tx_underrun <= 1'b0;
      if (frame_end) begin
        active       <= 1'b0;
        miso_oe      <= 1'b0;
        bit_cnt      <= '0;
        load_pending <= 1'b0;
        tx_sr        <= '0;
        rx_sr        <= '0;
      end else begin
        if (do_load) begin
          tx_sr        <= buf_full ? tx_buf : '0;
          tx_underrun  <= ~buf_full;
          load_pending <= 1'b0;
        end else if (drive_edge) begin
          tx_sr <= tx_shift;
        end
        if (frame_start) begin
          active       <= 1'b1;
          miso_oe      <= 1'b1;
          bit_cnt      <= '0;
          rx_sr        <= '0;
          load_pending <= cpha;
        end
        if (sample_edge) begin
          rx_sr <= rx_next;
          if (bit_cnt == LAST) begin
            bit_cnt      <= '0;
            load_pending <= 1'b1;
            rx_data      <= rx_next;
            rx_valid     <= 1'b1;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
          end
        end
      end
    end
  end

  // One-entry transmit buffer; a same-cycle load takes the old contents.
  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      buf_full <= 1'b0;
      tx_buf   <= '0;
    end else begin
      if (do_load) buf_full <= 1'b0;
      if (accept) begin
        tx_buf   <= tx_data;
        buf_full <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_spi_slave_if.sv
// Randomised bench for spi_slave_if: an MSB-first and an LSB-first instance share
// one SPI master; a word-level model predicts received words, miso words,
// underruns and buffer state.
module tb_spi_slave_if;
  localparam int W = 8;
  localparam int H = 6;  // sclk half period in clk_in cycles

  logic clk_in = 1'b0;
  logic rst_n, cpol, cpha, sclk, ss_n, mosi, tx_valid;
  logic [W-1:0] tx_data;
  logic miso_m, miso_oe_m, tx_ready_m, rx_valid_m, tx_underrun_m;
  logic miso_l, miso_oe_l, tx_ready_l, rx_valid_l, tx_underrun_l;
  logic [W-1:0] rx_data_m, rx_data_l;

  spi_slave_if #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (
    .clk_in(clk_in), .rst_n(rst_n), .cpol(cpol), .cpha(cpha), .sclk(sclk), .ss_n(ss_n),
    .mosi(mosi), .miso(miso_m), .miso_oe(miso_oe_m), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready_m), .rx_data(rx_data_m), .rx_valid(rx_valid_m), .tx_underrun(tx_underrun_m));

  spi_slave_if #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (
    .clk_in(clk_in), .rst_n(rst_n), .cpol(cpol), .cpha(cpha), .sclk(sclk), .ss_n(ss_n),
    .mosi(mosi), .miso(miso_l), .miso_oe(miso_oe_l), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready_l), .rx_data(rx_data_l), .rx_valid(rx_valid_l), .tx_underrun(tx_underrun_l));

  always #5 clk_in = ~clk_in;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk_in);
  endtask

  // Observed pulses, collected away from the active edge.
  logic [W-1:0] rxq_m[$], rxq_l[$];
  int ur_m = 0, ur_l = 0;
  always @(negedge clk_in) begin
    if (rx_valid_m) rxq_m.push_back(rx_data_m);
    if (rx_valid_l) rxq_l.push_back(rx_data_l);
    if (tx_underrun_m) ur_m = ur_m + 1;
    if (tx_underrun_l) ur_l = ur_l + 1;
  end

  // Reference model: one-entry buffer, list of words handed to the shifter.
  logic         mfull = 1'b0;
  logic [W-1:0] mval  = '0;
  int           m_ur  = 0;
  logic [W-1:0] exp_tx[$];
  logic [W-1:0] last_m = '0, last_l = '0;
  logic         wb[$], mo_m[$], mo_l[$];

  task automatic mload();
    if (mfull) exp_tx.push_back(mval);
    else begin
      exp_tx.push_back('0);
      m_ur++;
    end
    mfull = 1'b0;
  endtask

  task automatic push(input logic [W-1:0] v);
    chk("tx_ready_pre", 32'(tx_ready_m), 32'(!mfull));
    tx_data  = v;
    tx_valid = 1'b1;
    tick(1);
    tx_valid = 1'b0;
    mfull = 1'b1;
    mval  = v;
    tick(1);
    chk("tx_ready_post", 32'({tx_ready_m, tx_ready_l}), 32'(2'b00));
  endtask

  task automatic run_frame(input logic pol, input logic pha, input logic lsb_wire, input int nbits,
                           input logic [2:0][W-1:0] words, input logic pre_en, input logic [W-1:0] pre_val,
                           input logic [2:0] push_en, input logic [2:0][W-1:0] push_val, input logic keep_sel);
    int nw, rb_m, rb_l, u0_m, u0_l, mu0;
    nw = nbits / W;
    rb_m = rxq_m.size(); rb_l = rxq_l.size();
    u0_m = ur_m; u0_l = ur_l; mu0 = m_ur;
    exp_tx.delete(); wb.delete(); mo_m.delete(); mo_l.delete();
    for (int b = 0; b < nbits; b++)
      wb.push_back(lsb_wire ? words[b/W][b%W] : words[b/W][W-1-(b%W)]);
    if (pre_en && !mfull) push(pre_val);
    cpol = pol; cpha = pha; sclk = pol;
    tick(4);
    ss_n = 1'b0;
    if (!pha) begin
      mosi = wb[0];
      mload();
    end
    tick(H);
    chk("miso_oe_sel", 32'({miso_oe_m, miso_oe_l}), 32'(2'b11));
    chk("tx_ready_start", 32'(tx_ready_m), 32'(!mfull));
    for (int b = 0; b < nbits; b++) begin
      int i;
      i = b % W;
      if (!pha) begin
        mo_m.push_back(miso_m); mo_l.push_back(miso_l);
        sclk = ~pol; tick(H);
        sclk = pol;
        if (i == W-1) mload();
        if (b + 1 < nbits) mosi = wb[b+1];
        tick(H);
      end else begin
        sclk = ~pol; mosi = wb[b];
        if (i == 0) mload();
        tick(H);
        mo_m.push_back(miso_m); mo_l.push_back(miso_l);
        sclk = pol; tick(H);
      end
      if (i == 3 && push_en[b/W] && !mfull) push(push_val[b/W]);
    end
    if (!keep_sel) ss_n = 1'b1;
    tick(H);
    chk("rx_count_m", 32'(rxq_m.size() - rb_m), 32'(nw));
    chk("rx_count_l", 32'(rxq_l.size() - rb_l), 32'(nw));
    for (int w = 0; w < nw; w++) begin
      logic [W-1:0] em, el, gm, gl;
      for (int k = 0; k < W; k++) begin
        em[W-1-k] = wb[w*W+k];   el[k] = wb[w*W+k];
        gm[W-1-k] = mo_m[w*W+k]; gl[k] = mo_l[w*W+k];
      end
      if (rb_m + w < rxq_m.size()) chk("rx_word_m", 32'(rxq_m[rb_m+w]), 32'(em));
      if (rb_l + w < rxq_l.size()) chk("rx_word_l", 32'(rxq_l[rb_l+w]), 32'(el));
      chk("miso_word_m", 32'(gm), 32'(exp_tx[w]));
      chk("miso_word_l", 32'(gl), 32'(exp_tx[w]));
      last_m = em; last_l = el;
    end
    chk("rx_hold_m", 32'(rx_data_m), 32'(last_m));
    chk("rx_hold_l", 32'(rx_data_l), 32'(last_l));
    chk("underrun_m", 32'(ur_m - u0_m), 32'(m_ur - mu0));
    chk("underrun_l", 32'(ur_l - u0_l), 32'(m_ur - mu0));
    if (!keep_sel) begin
      chk("idle_oe_miso", 32'({miso_oe_m, miso_oe_l, miso_m, miso_l}), 32'(4'b0000));
      chk("tx_ready_end", 32'(tx_ready_m), 32'(!mfull));
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk(tag, 32'({miso_m, miso_oe_m, rx_valid_m, tx_underrun_m, tx_ready_m, rx_data_m}), 32'({5'b00001, 8'h00}));
    chk(tag, 32'({miso_l, miso_oe_l, rx_valid_l, tx_underrun_l, tx_ready_l, rx_data_l}), 32'({5'b00001, 8'h00}));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0; ss_n = 1'b1; sclk = 1'b0; mosi = 1'b0;
    cpol = 1'b0; cpha = 1'b0; tx_valid = 1'b0; tx_data = '0;
    tick(4);
    chk_reset_vals("reset");
    rst_n = 1'b1;
    tick(4);

    // Mode 0: preload A5, receive 3C.
    run_frame(1'b0, 1'b0, 1'b0, 8, 24'h00003C, 1'b1, 8'hA5, 3'b000, 24'h0, 1'b0);
    // Mode 3 back-to-back with a refill during word 1.
    run_frame(1'b1, 1'b1, 1'b0, 16, 24'h000FF0, 1'b1, 8'h12, 3'b001, 24'h000034, 1'b0);
    // Mode 1 with empty buffer.
    run_frame(1'b0, 1'b1, 1'b0, 8, 24'h000081, 1'b0, 8'h00, 3'b000, 24'h0, 1'b0);
    // Mode 2, LSB-first wire order.
    run_frame(1'b1, 1'b0, 1'b1, 8, 24'h00006B, 1'b1, 8'hC3, 3'b000, 24'h0, 1'b0);
    // Partial word discarded, then a full 55.
    run_frame(1'b0, 1'b0, 1'b0, 5, 24'h0000AA, 1'b0, 8'h00, 3'b000, 24'h0, 1'b0);
    run_frame(1'b0, 1'b0, 1'b0, 8, 24'h000055, 1'b0, 8'h00, 3'b000, 24'h0, 1'b0);

    // Reset mid-word with the buffer full; select held low through reset.
    run_frame(1'b0, 1'b0, 1'b0, 5, 24'h000033, 1'b1, 8'h5A, 3'b001, 24'h0000B7, 1'b1);
    chk("buf_full_before_rst", 32'(tx_ready_m), 32'(0));
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(1);
    chk_reset_vals("mid_reset");
    mfull = 1'b0; last_m = '0; last_l = '0;
    tick(8);
    chk("no_restart_oe", 32'({miso_oe_m, miso_oe_l}), 32'(2'b00));
    ss_n = 1'b1;
    tick(8);
    run_frame(1'b0, 1'b1, 1'b0, 8, 24'h0000E1, 1'b0, 8'h00, 3'b000, 24'h0, 1'b0);

    // Randomised frames.
    for (int r = 0; r < 12; r++) begin
      logic [1:0] mode;
      int nw;
      mode = 2'($urandom);
      nw = int'($urandom_range(1, 3));
      run_frame(mode[1], mode[0], 1'($urandom), nw * W, 24'($urandom), 1'($urandom), 8'($urandom),
                3'($urandom), 24'($urandom), 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
